// File: rtl/ifft_4point_stream.sv
// Streaming 4-point inverse FFT.
// Bins X[0..3] arrive one per transfer on the input side and are buffered.
// One compute cycle evaluates x[n] = (1/4) * sum X[k] * W4^(-nk).
// The four time samples then leave one per transfer on the output side.
//
// Handshake rule, both sides: a transfer happens on a rising clk edge where
// valid && ready are both high. The block never accepts a new frame while a
// result frame is still draining.
//
// The FSM state is exposed on dbg_state (0=LOAD, 1=COMPUTE, 2=OUTPUT).
module ifft_4point_stream #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_real,
    input  logic signed [WIDTH-1:0] in_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_real,
    output logic signed [WIDTH-1:0] out_imag,
    output logic                    out_last,
    output logic [1:0]              dbg_state
);

    localparam int EW = WIDTH + 2;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [1:0]              in_idx_q;
    logic [1:0]              out_idx_q;
    logic signed [WIDTH-1:0] bin_re_q [4];
    logic signed [WIDTH-1:0] bin_im_q [4];
    logic signed [WIDTH-1:0] res_re_q [4];
    logic signed [WIDTH-1:0] res_im_q [4];
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic signed [WIDTH-1:0] out_re_q;
    logic signed [WIDTH-1:0] out_im_q;

    // Butterfly results for the buffered frame, already scaled by 1/4.
    logic signed [WIDTH-1:0] res_re_d [4];
    logic signed [WIDTH-1:0] res_im_d [4];

    logic signed [EW-1:0] xr [4];
    logic signed [EW-1:0] xi [4];
    logic signed [EW-1:0] s0r, s0i, s1r, s1i, s2r, s2i, s3r, s3i;
    logic signed [EW-1:0] yr [4];
    logic signed [EW-1:0] yi [4];

    // Two radix-2 stages on sign-extended bins; the WIDTH+2 intermediate
    // holds the full 4x sum, so dropping the low two bits (floor /4)
    // always lands back inside WIDTH without overflow.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            xr[k] = EW'(bin_re_q[k]);
            xi[k] = EW'(bin_im_q[k]);
        end
        s0r = xr[0] + xr[2];
        s0i = xi[0] + xi[2];
        s2r = xr[0] - xr[2];
        s2i = xi[0] - xi[2];
        s1r = xr[1] + xr[3];
        s1i = xi[1] + xi[3];
        s3r = xr[1] - xr[3];
        s3i = xi[1] - xi[3];
        // j*(a+jb) = -b + ja
        yr[0] = s0r + s1r;
        yi[0] = s0i + s1i;
        yr[2] = s0r - s1r;
        yi[2] = s0i - s1i;
        yr[1] = s2r - s3i;
        yi[1] = s2i + s3r;
        yr[3] = s2r + s3i;
        yi[3] = s2i - s3r;
        for (int k = 0; k < 4; k++) begin
            res_re_d[k] = yr[k][EW-1:2];
            res_im_d[k] = yi[k][EW-1:2];
        end
    end

    // Frame sequencer: load four bins, compute once, drain four samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            in_idx_q    <= 2'd0;
            out_idx_q   <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            for (int k = 0; k < 4; k++) begin
                bin_re_q[k] <= '0;
                bin_im_q[k] <= '0;
                res_re_q[k] <= '0;
                res_im_q[k] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid && in_ready_q) begin
                        bin_re_q[in_idx_q] <= in_real;
                        bin_im_q[in_idx_q] <= in_imag;
                        in_idx_q           <= in_idx_q + 2'd1;
                        if (in_idx_q == 2'd3) begin
                            state_q    <= COMPUTE;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                COMPUTE: begin
                    for (int k = 0; k < 4; k++) begin
                        res_re_q[k] <= res_re_d[k];
                        res_im_q[k] <= res_im_d[k];
                    end
                    out_idx_q   <= 2'd0;
                    out_re_q    <= res_re_d[0];
                    out_im_q    <= res_im_d[0];
                    out_last_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        if (out_idx_q == 2'd3) begin
                            out_idx_q   <= 2'd0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= LOAD;
                        end else begin
                            out_idx_q  <= out_idx_q + 2'd1;
                            out_re_q   <= res_re_q[out_idx_q + 2'd1];
                            out_im_q   <= res_im_q[out_idx_q + 2'd1];
                            out_last_q <= (out_idx_q == 2'd2);
                        end
                    end
                end
                default: begin
                    state_q     <= LOAD;
                    in_idx_q    <= 2'd0;
                    out_idx_q   <= 2'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_real  = out_re_q;
    assign out_imag  = out_im_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ifft_4point_stream.sv
// Directed bench for ifft_4point_stream: table of frames with hand-computed
// results, plus sequences for backpressure, ignored input and async reset.
module tb_ifft_4point_stream;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_real;
  logic signed [15:0] in_imag;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_real;
  logic signed [15:0] out_imag;
  logic               out_last;
  logic [1:0]         dbg_state;

  ifft_4point_stream #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];  // {last, re[15:0], im[15:0]}

  typedef struct {
    int xr[4];
    int xi[4];
    int yr[4];
    int yi[4];
  } vec_t;

  vec_t vecs[5];
  int pat_tbl[8];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one bin starting at a negedge; returns at the negedge after accept.
  task automatic send_bin(input int re, input int im);
    int t = 0;
    in_valid = 1'b1;
    in_real  = re[15:0];
    in_imag  = im[15:0];
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", t, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drain nsamp samples; use_pat selects the stall pattern, garbage drives
  // in_valid with random data throughout.
  task automatic recv(input int use_pat, input int garbage, input int nsamp);
    int got = 0;
    int cyc = 0;
    int stalled = 0;
    int rdy_bad = 0;
    int hr = 0, hi = 0, hl = 0;
    logic [32:0] e;
    while (got < nsamp && cyc < 100) begin
      out_ready = use_pat ? (pat_tbl[cyc % 8] != 0) : 1'b1;
      if (garbage != 0) begin
        in_valid = 1'b1;
        in_real  = 16'($urandom);
        in_imag  = 16'($urandom);
      end
      if (in_ready) rdy_bad = 1;
      if (stalled != 0) begin
        check("stall_hold_valid", int'(out_valid), 1);
        check("stall_hold_re", int'(out_real), hr);
        check("stall_hold_im", int'(out_imag), hi);
        check("stall_hold_last", int'(out_last), hl);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("x%0d_re", got), int'(out_real), int'($signed(e[31:16])));
          check($sformatf("x%0d_im", got), int'(out_imag), int'($signed(e[15:0])));
          check($sformatf("x%0d_last", got), int'(out_last), int'(e[32]));
        end
        got++;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        hr = int'(out_real);
        hi = int'(out_imag);
        hl = int'(out_last);
      end else begin
        stalled = 0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (cyc >= 100) check("recv_timeout", got, nsamp);
    check("in_ready_low_in_output", rdy_bad, 0);
    if (nsamp == 4) begin
      check("in_ready_after_drain", int'(in_ready), 1);
      check("out_valid_after_drain", int'(out_valid), 0);
    end
  endtask

  // Full frame: queue expectations, load bins, check the compute-cycle
  // latency, then drain.
  task automatic run_frame(input vec_t v, input int use_pat, input int garbage,
                           input int nsamp);
    for (int n = 0; n < 4; n++)
      exp_q.push_back({(n == 3), v.yr[n][15:0], v.yi[n][15:0]});
    for (int n = 0; n < 4; n++) send_bin(v.xr[n], v.xi[n]);
    check("lat_compute_valid", int'(out_valid), 0);
    check("lat_compute_state", int'(dbg_state), 1);
    check("lat_compute_ready", int'(in_ready), 0);
    if (garbage != 0) begin
      in_valid = 1'b1;
      in_real  = 16'($urandom);
      in_imag  = 16'($urandom);
    end
    @(negedge clk);
    check("lat_output_valid", int'(out_valid), 1);
    recv(use_pat, garbage, nsamp);
  endtask

  // Assert reset between edges and confirm outputs clear before any clock.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_real", int'(out_real), 0);
    check("rst_out_imag", int'(out_imag), 0);
    check("rst_state", int'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    pat_tbl = '{0, 0, 1, 0, 1, 1, 0, 1};

    // impulse
    vecs[0].xr = '{4000, 0, 0, 0};       vecs[0].xi = '{0, 0, 0, 0};
    vecs[0].yr = '{1000, 1000, 1000, 1000}; vecs[0].yi = '{0, 0, 0, 0};
    // single tone at k=1
    vecs[1].xr = '{0, 4000, 0, 0};       vecs[1].xi = '{0, 0, 0, 0};
    vecs[1].yr = '{1000, 0, -1000, 0};   vecs[1].yi = '{0, 1000, 0, -1000};
    // full scale positive
    vecs[2].xr = '{32767, 32767, 32767, 32767}; vecs[2].xi = '{0, 0, 0, 0};
    vecs[2].yr = '{32767, 0, 0, 0};      vecs[2].yi = '{0, 0, 0, 0};
    // full scale negative
    vecs[3].xr = '{-32768, -32768, -32768, -32768}; vecs[3].xi = '{0, 0, 0, 0};
    vecs[3].yr = '{-32768, 0, 0, 0};     vecs[3].yi = '{0, 0, 0, 0};
    // floor rounding of -1/4
    vecs[4].xr = '{-1, 0, 0, 0};         vecs[4].xi = '{0, 0, 0, 0};
    vecs[4].yr = '{-1, -1, -1, -1};      vecs[4].yi = '{0, 0, 0, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_out_real", int'(out_real), 0);
    check("reset_state", int'(dbg_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven frames, out_ready held high
    for (int i = 0; i < 5; i++) run_frame(vecs[i], 0, 0, 4);

    // backpressure pattern on the tone frame
    run_frame(vecs[1], 1, 0, 4);

    // garbage on in_valid during COMPUTE/OUTPUT, then back-to-back frames
    run_frame(vecs[4], 0, 1, 4);
    run_frame(vecs[0], 0, 0, 4);
    run_frame(vecs[1], 0, 0, 4);

    // reset after two bins loaded
    send_bin(4000, 0);
    send_bin(0, 0);
    async_reset();
    run_frame(vecs[0], 0, 0, 4);

    // reset with the last sample still pending in OUTPUT
    run_frame(vecs[1], 0, 0, 3);
    check("pending_valid_before_rst", int'(out_valid), 1);
    async_reset();
    run_frame(vecs[0], 0, 0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
